rr_arbiter_4: RTL

Four-way round-robin arbiter that shares one downstream resource, such as a 4-to-2 encoder or shared datapath slot, among four requesters. Each request line is one input of the classic d3..d0 encoder arrangement. The block adds:
- rotating priority,
- a registered one-hot grant plus its 2-bit encoded index,
- a release handshake,
- a hold-time limit so no requester can starve the others.

It sits between the requesting units and the shared resource and sequences which requester drives it each cycle.

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick4.sv | 42 ++++
 rtl/rr_arbiter_4.sv | 106 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family: sizes, state
// encoding, reset pointer and a one-hot helper.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [IDX_W-1:0] PTR_RESET = 2'd0;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder: finds the first set request
// bit scanning from ptr upward, modulo 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rotated_s;
    logic [IDX_W-1:0] offset_s;

    // Rotate the requests so that bit 0 is the requester at ptr.
    always_comb begin
        rotated_s = req;
        case (ptr)
            2'd0:    rotated_s = req;
            2'd1:    rotated_s = {req[0],   req[3:1]};
            2'd2:    rotated_s = {req[1:0], req[3:2]};
            2'd3:    rotated_s = {req[2:0], req[3]};
            default: rotated_s = req;
        endcase
    end

    // Fixed-priority search over the rotated vector.
    always_comb begin
        offset_s = 2'd0;
        casez (rotated_s)
            4'b???1: offset_s = 2'd0;
            4'b??10: offset_s = 2'd1;
            4'b?100: offset_s = 2'd2;
            4'b1000: offset_s = 2'd3;
            default: offset_s = 2'd0;
        endcase
    end

    assign idx = ptr + offset_s;
    assign any = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, release
// handshake and an optional hold-time limit.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit HOLD_LIMIT_EN = (MAX_HOLD != 0);

    arb_state_e       state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [CNT_W-1:0] cnt_r;

    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic             owner_req_s;
    logic             limit_hit_s;
    logic             release_s;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Release conditions for the current owner; only meaningful in BUSY.
    always_comb begin
        owner_req_s = req[gnt_idx];
        limit_hit_s = 1'b0;
        if (HOLD_LIMIT_EN) begin
            limit_hit_s = (cnt_r == CNT_LAST);
        end else begin
            limit_hit_s = 1'b0;
        end
        release_s = done || !owner_req_s || limit_hit_s;
    end

    // Arbiter FSM with registered grant, pointer, hold counter and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= PTR_RESET;
            cnt_r     <= '0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timeout <= 1'b0;
                    cnt_r   <= '0;
                    if (pick_any_s) begin
                        gnt       <= idx_to_onehot(pick_idx_s);
                        gnt_idx   <= pick_idx_s;
                        gnt_valid <= 1'b1;
                        state_r   <= BUSY;
                    end else begin
                        gnt       <= 4'b0000;
                        gnt_idx   <= 2'd0;
                        gnt_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                BUSY: begin
                    if (release_s) begin
                        gnt       <= 4'b0000;
                        gnt_idx   <= 2'd0;
                        gnt_valid <= 1'b0;
                        ptr_r     <= gnt_idx + 2'd1;
                        cnt_r     <= '0;
                        // A hold-limit release coinciding with done or a drop is a normal release.
                        timeout   <= limit_hit_s && !done && owner_req_s;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        timeout <= 1'b0;
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    gnt       <= 4'b0000;
                    gnt_idx   <= 2'd0;
                    gnt_valid <= 1'b0;
                    timeout   <= 1'b0;
                    cnt_r     <= '0;
                end
            endcase
        end
    end

endmodule
